// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg
//   Shared definitions for the FIFO write-port arbiter.
//   - arb_state_t : arbiter FSM state encoding (IDLE / GRANT)
//   - clog2_min1  : ceil(log2(n)), never less than 1, for sizing index and count fields
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Returns the first set request bit found
//   scanning upward from last+1, wrapping modulo NREQ.
// Ports
//   req      in   NREQ   request vector
//   last     in   IDW    index granted most recently
//   gnt_idx  out  IDW    picked index (0 when nothing is requesting)
//   any      out  1      at least one request bit is set
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    localparam int W2 = 2 * NREQ;

    logic [W2-1:0] dbl;
    logic [W2-1:0] masked;

    // The request vector is laid out twice so the wrap-around scan becomes a
    // plain lowest-set-bit search over the window (last, last+NREQ].
    always_comb begin
        dbl    = {req, req};
        masked = '0;
        for (int i = 0; i < W2; i++) begin
            if ((i > int'(last)) && (i <= int'(last) + NREQ)) begin
                masked[i] = dbl[i];
            end
        end
    end

    // Scanned from the top down so the lowest set bit is the last one written.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = W2 - 1; i >= 0; i--) begin
            if (masked[i]) begin
                gnt_idx = IDW'(i % NREQ);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the write port of one FIFO between NREQ producers. Round-robin
//   arbitration with at most BURST accepted beats per grant; every release is
//   followed by one IDLE cycle before the next grant.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no grant; pick next requester after last_gnt, no beat taken
//   ST_GRANT | gnt_id owns the FIFO write port until burst end or valid drop
//
// Ports
//   clk         in   1             rising-edge clock
//   rst         in   1             synchronous reset, active-high
//   req_valid   in   NREQ          requester i has a word on its req_data slice
//   req_data    in   NREQ*DWIDTH   flat bus, slice i = [i*DWIDTH +: DWIDTH]
//   req_ready   out  NREQ          one-hot or zero; beat accepted on valid & ready
//   fifo_full   in   1             FIFO full flag
//   fifo_wr_en  out  1             FIFO write strobe
//   fifo_data   out  DWIDTH        FIFO write data (slice gnt_id)
//   busy        out  1             a grant is active
//   gnt_id      out  clog2(NREQ)   current or most recent granted requester
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8,
    parameter int BURST  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [DWIDTH-1:0]        fifo_data,
    output logic                     busy,
    output logic [clog2_min1(NREQ)-1:0] gnt_id
);

    localparam int IDW = clog2_min1(NREQ);
    localparam int BCW = clog2_min1(BURST);

    arb_state_t     state;
    arb_state_t     state_nxt;
    logic [IDW-1:0] last_gnt;
    logic [BCW-1:0] beat_cnt;

    logic [IDW-1:0] pick_idx;
    logic           pick_any;
    logic           load_pick;
    logic           accept;
    logic           gnt_valid;
    logic           beat_last;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req     (req_valid),
        .last    (last_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign gnt_valid = req_valid[gnt_id];
    assign beat_last = (beat_cnt == BCW'(BURST - 1));
    assign fifo_data = req_data[int'(gnt_id) * DWIDTH +: DWIDTH];
    assign busy      = (state == ST_GRANT);

    // ready does not look at rst: a beat presented in a reset cycle is simply
    // not counted, because the reset wins in the register update below.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        load_pick  = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nxt = ST_GRANT;
                    load_pick = 1'b1;
                end
            end
            ST_GRANT: begin
                if (gnt_valid && !fifo_full) begin
                    accept            = 1'b1;
                    req_ready[gnt_id] = 1'b1;
                    fifo_wr_en        = 1'b1;
                    if (beat_last) begin
                        state_nxt = ST_IDLE;
                    end
                end else if (!gnt_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt_id   <= '0;
            last_gnt <= IDW'(NREQ - 1);
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load_pick) begin
                gnt_id   <= pick_idx;
                last_gnt <= pick_idx;
                beat_cnt <= '0;
            end else if (accept && !beat_last) begin
                // The final beat of a burst releases the grant instead of
                // wrapping the counter; it is cleared on the next pick.
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int NREQ   = 4;
    localparam int DWIDTH = 8;
    localparam int BURST  = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DWIDTH-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   fifo_full;
    logic                   fifo_wr_en;
    logic [DWIDTH-1:0]      fifo_data;
    logic                   busy;
    logic [1:0]             gnt_id;

    fifo_wr_arbiter #(
        .NREQ   (NREQ),
        .DWIDTH (DWIDTH),
        .BURST  (BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .busy       (busy),
        .gnt_id     (gnt_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int data;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Producer model and per-test schedule
    int         rel;
    int         rst_rel;
    int         full_lo;
    int         full_hi;
    int         rem[NREQ];
    int         start[NREQ];
    logic [3:0] seq[NREQ];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, rel);
        end
    endtask

    task automatic push(input int id, input int data, input int cyc);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    // Producer i drives {A+i, seq}: A0.. for req0, B0.. for req1, etc.
    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]                 = (rem[i] > 0) && (rel >= start[i]);
            req_data[i*DWIDTH +: DWIDTH] = {4'hA + 4'(i), seq[i]};
        end
        fifo_full = (rel >= full_lo) && (rel < full_hi);
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (!rst && req_valid[i] && req_ready[i]) begin
                seq[i] = seq[i] + 4'd1;
                rem[i] = rem[i] - 1;
            end
        end
        @(posedge clk);
        #1;
        rel = rel + 1;
        rst = (rel == rst_rel);
        apply();
    endtask

    task automatic run_to(input int n);
        while (rel < n) tick();
    endtask

    task automatic do_reset();
        chk("beats_missing", sb.size(), 0);
        sb.delete();
        rst     = 1'b1;
        rst_rel = -1;
        full_lo = 0;
        full_hi = 0;
        rel     = 0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i]   = 0;
            start[i] = 0;
            seq[i]   = 4'd0;
        end
        apply();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_gnt_id", gnt_id, 0);
        chk("rst_fifo_data", fifo_data, 8'hA0);
        @(posedge clk);
        #1;
        rel = 0;
    endtask

    // Monitor: protocol checks every cycle, scoreboard pop on each write.
    exp_t e_mon;
    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_onehot0", int'($onehot0(req_ready)), 1);
            chk("wr_en_vs_ready", fifo_wr_en, |req_ready);
            if (fifo_full) chk("wr_while_full", fifo_wr_en, 0);
            if (busy) chk("data_mux", fifo_data, req_data[int'(gnt_id)*DWIDTH +: DWIDTH]);
            if (fifo_wr_en) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got id %0d data 0x%0h, required none (cycle %0d)",
                             gnt_id, fifo_data, rel);
                end else begin
                    e_mon = sb.pop_front();
                    chk("beat_id", gnt_id, e_mon.id);
                    chk("beat_data", fifo_data, e_mon.data);
                    chk("beat_cycle", rel, e_mon.cyc);
                    chk("beat_ready", req_ready, 1 << e_mon.id);
                end
            end
        end
    end

    initial begin
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;

        // 1: single requester, 6 beats: 4-beat burst, bubble, re-grant, 2 beats
        do_reset();
        rem[0] = 6;
        apply();
        push(0, 8'hA0, 1); push(0, 8'hA1, 2); push(0, 8'hA2, 3); push(0, 8'hA3, 4);
        push(0, 8'hA4, 6); push(0, 8'hA5, 7);
        run_to(10);

        // 2: all valid, order 0,1,2,3,0 with 4 beats each and one bubble between
        do_reset();
        rem[0] = 8; rem[1] = 4; rem[2] = 4; rem[3] = 4;
        apply();
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 4; b++) begin
                push(g % 4, ((8'hA0 + 16 * (g % 4)) + (g == 4 ? 4 : 0) + b), 1 + 5 * g + b);
            end
        end
        run_to(26);

        // 3: req1 stalls 5 cycles on fifo_full after two beats
        do_reset();
        rem[1]  = 4;
        full_lo = 3;
        full_hi = 8;
        apply();
        push(1, 8'hB0, 1); push(1, 8'hB1, 2); push(1, 8'hB2, 8); push(1, 8'hB3, 9);
        while (rel < 12) begin
            tick();
            if (rel >= 3 && rel < 8) begin
                #2;
                chk("stall_busy", busy, 1);
                chk("stall_ready", req_ready, 0);
                chk("stall_wr_en", fifo_wr_en, 0);
            end
        end

        // 4: req2 drops after one beat; req3 wins over late req0 since last_gnt=2
        do_reset();
        rem[2] = 1; rem[3] = 4;
        rem[0] = 1; start[0] = 2;
        apply();
        push(2, 8'hC0, 1);
        push(3, 8'hD0, 4); push(3, 8'hD1, 5); push(3, 8'hD2, 6); push(3, 8'hD3, 7);
        push(0, 8'hA0, 9);
        run_to(12);

        // 5: reset mid-burst drops the in-flight beat; req0 wins first after reset
        do_reset();
        rem[0] = 8; rem[1] = 4; rem[2] = 4; rem[3] = 4;
        rst_rel = 3;
        apply();
        push(0, 8'hA0, 1); push(0, 8'hA1, 2);
        push(0, 8'hA2, 5); push(0, 8'hA3, 6); push(0, 8'hA4, 7); push(0, 8'hA5, 8);
        push(1, 8'hB0, 10);
        while (rel < 11) begin
            tick();
            if (rel == 4) begin
                #2;
                chk("post_rst_busy", busy, 0);
                chk("post_rst_ready", req_ready, 0);
                chk("post_rst_gnt_id", gnt_id, 0);
            end
        end

        do_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
